// File: rtl/alu_seq_ctrl_if.sv
// Bundle for the alu_seq_ctrl request/result handshakes and the selector bus.
// The controller uses the slave view; the decode stage, selector and consumer use the master view.
interface alu_seq_ctrl_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_func;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;

    logic [3:0]   sel;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_z;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_z;

    modport slave (
        input  in_valid, in_func, in_a, in_b, alu_z, out_ready,
        output in_ready, sel, alu_a, alu_b, out_valid, out_z
    );

    modport master (
        output in_valid, in_func, in_a, in_b, alu_z, out_ready,
        input  in_ready, sel, alu_a, alu_b, out_valid, out_z
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the ALU function selector: runs single-cycle functions
// once, and builds variable shifts (codes 8/9) from repeated shift-by-one passes.
module alu_seq_ctrl #(
    parameter int N   = 8,
    parameter int SHW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     func;
    logic [SHW-1:0] cnt;
    logic [N-1:0]   work;
    logic [N-1:0]   b;
    logic [N-1:0]   alu_a_hold;
    logic [N-1:0]   alu_b_hold;
    logic [N-1:0]   out_z_q;

    logic accept;
    logic in_is_shift;
    logic in_cnt_zero;
    logic active;
    logic last_iter;

    assign accept      = bus.in_valid && (state == IDLE);
    assign in_is_shift = (bus.in_func == 4'd8) || (bus.in_func == 4'd9);
    assign in_cnt_zero = (bus.in_b[SHW-1:0] == '0);
    assign active      = (state == EXEC) || (state == ITER);
    assign last_iter   = (cnt == SHW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_is_shift)
                        state_next = EXEC;
                    else if (in_cnt_zero)
                        state_next = DONE;
                    else
                        state_next = ITER;
                end
            end
            EXEC: state_next = DONE;
            ITER: if (last_iter) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The hold registers remember what was last driven so the operand buses stay put outside EXEC/ITER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func       <= '0;
            cnt        <= '0;
            work       <= '0;
            b          <= '0;
            alu_a_hold <= '0;
            alu_b_hold <= '0;
            out_z_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        func <= bus.in_func;
                        work <= bus.in_a;
                        b    <= bus.in_b;
                        cnt  <= bus.in_b[SHW-1:0];
                        if (in_is_shift && in_cnt_zero)
                            out_z_q <= bus.in_a;
                    end
                end
                EXEC: begin
                    alu_a_hold <= work;
                    alu_b_hold <= b;
                    out_z_q    <= bus.alu_z;
                end
                ITER: begin
                    alu_a_hold <= work;
                    alu_b_hold <= b;
                    work       <= bus.alu_z;
                    cnt        <= cnt - SHW'(1);
                    if (last_iter)
                        out_z_q <= bus.alu_z;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign busy          = (state != IDLE);
    assign bus.sel       = active ? func : 4'd0;
    assign bus.alu_a     = active ? work : alu_a_hold;
    assign bus.alu_b     = active ? b    : alu_b_hold;
    assign bus.out_z     = out_z_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases plus randomized operations
// checked against a result/latency reference model and a behavioural selector.
module tb_alu_seq_ctrl;

    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    int checks = 0;
    int passes = 0;

    alu_seq_ctrl_if #(.N(N)) bus();

    alu_seq_ctrl #(.N(N), .SHW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Selector stand-in: F0 add, F8/F9 shift by one, the remaining codes arbitrary but fixed.
    function automatic logic [7:0] sel_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd8:    return a << 1;
            4'd9:    return a >> 1;
            default: return a + b + 8'(f);
        endcase
    endfunction

    always_comb bus.alu_z = sel_fn(bus.sel, bus.alu_a, bus.alu_b);

    function automatic logic [7:0] ref_result(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        if (f == 4'd8) return a << b[2:0];
        if (f == 4'd9) return a >> b[2:0];
        return sel_fn(f, a, b);
    endfunction

    // Clock edges after the accept edge until out_valid is first seen high.
    function automatic int ref_latency(input logic [3:0] f, input logic [7:0] b);
        if (f == 4'd8 || f == 4'd9) return int'(b[2:0]);
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic drive_junk();
        bus.in_func = 4'($urandom);
        bus.in_a    = 8'($urandom);
        bus.in_b    = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [7:0] exp_z;
        int         exp_lat;
        int         edges;
        int         sel_hits;
        exp_z   = ref_result(f, a, b);
        exp_lat = ref_latency(f, b);

        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drive_junk();

        edges    = 0;
        sel_hits = 0;
        while (bus.out_valid !== 1'b1 && edges < 40) begin
            if (edges == 0) begin
                checkOutput("first_sel", bus.sel, f);
                checkOutput("first_alu_a", bus.alu_a, a);
                checkOutput("first_alu_b", bus.alu_b, b);
            end
            if (bus.sel == f) sel_hits++;
            checkOutput("run_in_ready", bus.in_ready, 0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", edges, exp_lat);
        checkOutput("sel_cycles", sel_hits, exp_lat);
        checkOutput("done_sel", bus.sel, 0);
        checkOutput("out_z", bus.out_z, exp_z);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_in_ready", bus.in_ready, 0);

        // Backpressure: a competing request with fresh operands must be ignored.
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            drive_junk();
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_out_valid", bus.out_valid, 1);
            checkOutput("stall_out_z", bus.out_z, exp_z);
            checkOutput("stall_in_ready", bus.in_ready, 0);
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("ret_in_ready", bus.in_ready, 1);
        checkOutput("ret_out_valid", bus.out_valid, 0);
        checkOutput("ret_busy", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_sel"}, bus.sel, 0);
        checkOutput({tag, "_alu_a"}, bus.alu_a, 0);
        checkOutput({tag, "_alu_b"}, bus.alu_b, 0);
        checkOutput({tag, "_out_z"}, bus.out_z, 0);
        checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_func  = 4'd8;
        bus.in_a     = 8'h01;
        bus.in_b     = 8'h07;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_sel", bus.sel, 8);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("dropped_out_valid", bus.out_valid, 0);
            checkOutput("post_reset_in_ready", bus.in_ready, 1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_func   = 4'd0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;

        #1 rst_n = 1'b0;
        #2 check_reset_values("reset");
        #19 rst_n = 1'b1;

        applyStimulus(4'd0, 8'h35, 8'h0A, 0);
        applyStimulus(4'd8, 8'h03, 8'h03, 0);
        applyStimulus(4'd9, 8'hF0, 8'hFB, 0);
        applyStimulus(4'd9, 8'h80, 8'h00, 0);
        applyStimulus(4'd8, 8'h01, 8'h07, 0);
        applyStimulus(4'd1, 8'h5A, 8'h13, 5);
        applyStimulus(4'd0, 8'h10, 8'h20, 0);

        reset_mid_shift();
        applyStimulus(4'd3, 8'h0F, 8'hA0, 1);

        for (int n = 0; n < 40; n++)
            applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
